player_motion_ctrl: RTL and testbench

Per-frame motion controller for the player sprite. It owns the player's jump/fall physics, horizontal steering, screen-scroll requests and death detection. Its registered pos_x/pos_y outputs drive the player sprite address generator. The platform/scroll logic consumes scroll_vld/scroll_amt, and the game FSM consumes dead/bounce.

---
 rtl/player_motion_ctrl.sv | 165 ++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player jump/fall physics, steering, scroll requests and death detect.
// Define PLAYER_WRAP_EN for horizontal wrap-around; the default build clamps pos_x on screen.
//
// state | meaning
// IDLE  | waiting for start, frame ticks ignored
// RISE  | vel_y <= 0, moving up or at apex, land ignored
// FALL  | vel_y > 0, land bounces, floor kills
// DEAD  | hit bottom, all held until start
module player_motion_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int PLAYER_W = 40,
  parameter int PLAYER_H = 40,
  parameter int START_X  = 300,
  parameter int START_Y  = 400,
  parameter int SCROLL_Y = 160,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12,
  parameter int STEP_X   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       land,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [7:0] vel_y,
  output logic [1:0] state,
  output logic       bounce,
  output logic       scroll_vld,
  output logic [5:0] scroll_amt,
  output logic       dead
);

  typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2, DEAD = 2'd3} state_t;

  localparam logic signed [11:0] SCROLL_Y12 = 12'(SCROLL_Y);
  localparam logic signed [11:0] FLOOR12    = 12'(SCREEN_H - PLAYER_H);
  localparam logic [9:0]         SCROLL_Y10 = 10'(SCROLL_Y);
  localparam logic [9:0]         FLOOR10    = 10'(SCREEN_H - PLAYER_H);
  localparam logic [9:0]         START_X10  = 10'(START_X);
  localparam logic [9:0]         START_Y10  = 10'(START_Y);
  localparam logic signed [7:0]  JUMP8      = 8'(JUMP_V);
  localparam logic signed [8:0]  GRAV9      = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF9      = 9'(MAX_FALL);
  localparam logic signed [10:0] STEP11     = 11'(STEP_X);
`ifdef PLAYER_WRAP_EN
  localparam logic signed [10:0] SW11       = 11'(SCREEN_W);
`else
  localparam logic signed [10:0] XMAX11     = 11'(SCREEN_W - PLAYER_W);
`endif

  state_t             state_q;
  logic [9:0]         pos_x_q, pos_y_q;
  logic signed [7:0]  vel_y_q;
  logic               bounce_q, scroll_vld_q, dead_q;
  logic [5:0]         scroll_amt_q;

  logic signed [10:0] x_tmp;
  logic [9:0]         x_d;
  logic signed [11:0] y_tmp;
  logic               scroll_d;
  logic [5:0]         amt_d;
  logic signed [8:0]  vel_inc;
  logic signed [7:0]  vel_d;

  always_comb begin
    x_tmp = $signed({1'b0, pos_x_q});
    if (btn_left && !btn_right)
      x_tmp = x_tmp - STEP11;
    else if (btn_right && !btn_left)
      x_tmp = x_tmp + STEP11;
`ifdef PLAYER_WRAP_EN
    if (x_tmp < 11'sd0)
      x_d = 10'(x_tmp + SW11);
    else if (x_tmp >= SW11)
      x_d = 10'(x_tmp - SW11);
    else
      x_d = 10'(x_tmp);
`else
    if (x_tmp < 11'sd0)
      x_d = '0;
    else if (x_tmp > XMAX11)
      x_d = 10'(XMAX11);
    else
      x_d = 10'(x_tmp);
`endif
    // Pre-update velocity moves the sprite; the new velocity takes effect next frame.
    y_tmp    = $signed({2'b00, pos_y_q}) + $signed({{4{vel_y_q[7]}}, vel_y_q});
    scroll_d = (y_tmp < SCROLL_Y12);
    amt_d    = 6'(SCROLL_Y12 - y_tmp);
    vel_inc  = $signed({vel_y_q[7], vel_y_q}) + GRAV9;
    vel_d    = (vel_inc > MAXF9) ? 8'(MAXF9) : 8'(vel_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pos_x_q      <= START_X10;
      pos_y_q      <= START_Y10;
      vel_y_q      <= '0;
      bounce_q     <= 1'b0;
      scroll_vld_q <= 1'b0;
      scroll_amt_q <= '0;
      dead_q       <= 1'b0;
    end else begin
      bounce_q     <= 1'b0;
      scroll_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            vel_y_q <= -JUMP8;
            state_q <= RISE;
          end
        end
        RISE, FALL: begin
          if (frame_tick) begin
            pos_x_q      <= x_d;
            pos_y_q      <= scroll_d ? SCROLL_Y10 : 10'(y_tmp);
            scroll_vld_q <= scroll_d;
            scroll_amt_q <= scroll_d ? amt_d : '0;
            if (state_q == FALL && land) begin
              vel_y_q  <= -JUMP8;
              state_q  <= RISE;
              bounce_q <= 1'b1;
            end else if (state_q == FALL && y_tmp >= FLOOR12) begin
              pos_y_q <= FLOOR10;
              vel_y_q <= '0;
              state_q <= DEAD;
              dead_q  <= 1'b1;
            end else begin
              vel_y_q <= vel_d;
              state_q <= (vel_d > 8'sd0) ? FALL : RISE;
            end
          end
        end
        DEAD: begin
          if (start) begin
            state_q      <= IDLE;
            pos_x_q      <= START_X10;
            pos_y_q      <= START_Y10;
            vel_y_q      <= '0;
            scroll_amt_q <= '0;
            dead_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign vel_y      = vel_y_q;
  assign state      = state_q;
  assign bounce     = bounce_q;
  assign scroll_vld = scroll_vld_q;
  assign scroll_amt = scroll_amt_q;
  assign dead       = dead_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: two instances (default scroll line and SCROLL_Y=395)
// share stimulus; expectations come from a behavioural model plus hand-computed checkpoints.
module tb_player_motion_ctrl;

  localparam int N = -9999;

  logic clk = 1'b1;
  logic rst_n, frame_tick, start, btn_left, btn_right, land;

  logic [9:0] px0, py0, px1, py1;
  logic [7:0] vy0, vy1;
  logic [1:0] st0, st1;
  logic       b0, sv0, d0, b1, sv1, d1;
  logic [5:0] sa0, sa1;

  always #5 clk = ~clk;

  player_motion_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .land(land),
    .pos_x(px0), .pos_y(py0), .vel_y(vy0), .state(st0), .bounce(b0),
    .scroll_vld(sv0), .scroll_amt(sa0), .dead(d0)
  );

  player_motion_ctrl #(.SCROLL_Y(395)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .land(land),
    .pos_x(px1), .pos_y(py1), .vel_y(vy1), .state(st1), .bounce(b1),
    .scroll_vld(sv1), .scroll_amt(sa1), .dead(d1)
  );

  typedef struct {
    int x; int y; int v; int s;
    bit b; bit sv; bit d; bit chk_amt; int amt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  int mx[2], my[2], mv[2], ms[2];
  int hx[2], hy[2], hv[2], hs[2], hamt[2];

  task automatic cmp(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  task automatic hand(input int i, input int x, input int y, input int v, input int s, input int amt);
    hx[i] = x; hy[i] = y; hv[i] = v; hs[i] = s; hamt[i] = amt;
  endtask

  task automatic model_reset(input int i);
    mx[i] = 300; my[i] = 400; mv[i] = 0; ms[i] = 0;
  endtask

  task automatic model_step(input int i, input bit rn, input bit tk, input bit st,
                            input bit l, input bit r, input bit ld, output exp_t e);
    int nx, ny, sy;
    sy = (i == 0) ? 160 : 395;
    e.b = 0; e.sv = 0; e.chk_amt = 0; e.amt = 0;
    if (!rn) begin
      model_reset(i);
      e.chk_amt = 1;
    end else if (ms[i] == 0) begin
      if (st) begin mv[i] = -12; ms[i] = 1; end
    end else if (ms[i] == 3) begin
      if (st) begin model_reset(i); e.chk_amt = 1; end
    end else if (tk) begin
      nx = mx[i];
      if (l && !r) nx = nx - 4;
      if (r && !l) nx = nx + 4;
`ifdef PLAYER_WRAP_EN
      if (nx < 0) nx = nx + 640;
      else if (nx >= 640) nx = nx - 640;
`else
      if (nx < 0) nx = 0;
      if (nx > 600) nx = 600;
`endif
      mx[i] = nx;
      ny = my[i] + mv[i];
      e.chk_amt = 1;
      if (ny < sy) begin my[i] = sy; e.sv = 1; e.amt = sy - ny; end
      else my[i] = ny;
      if (ms[i] == 2 && ld) begin
        mv[i] = -12; ms[i] = 1; e.b = 1;
      end else if (ms[i] == 2 && ny >= 440) begin
        my[i] = 440; mv[i] = 0; ms[i] = 3;
      end else begin
        mv[i] = (mv[i] + 1 > 12) ? 12 : mv[i] + 1;
        ms[i] = (mv[i] > 0) ? 2 : 1;
      end
    end
    e.x = mx[i]; e.y = my[i]; e.v = mv[i]; e.s = ms[i]; e.d = (ms[i] == 3);
    if (hx[i] != N) e.x = hx[i];
    if (hy[i] != N) e.y = hy[i];
    if (hv[i] != N) e.v = hv[i];
    if (hs[i] != N) e.s = hs[i];
    if (hamt[i] != N) begin e.chk_amt = 1; e.amt = hamt[i]; end
    hand(i, N, N, N, N, N);
  endtask

  // One event cycle followed by one quiet cycle, so single-cycle pulses are checked both ways.
  task automatic ev(input bit tk, input bit st, input bit l, input bit r, input bit ld, input bit rn);
    exp_t e;
    @(negedge clk);
    frame_tick = tk; start = st; btn_left = l; btn_right = r; land = ld; rst_n = rn;
    model_step(0, rn, tk, st, l, r, ld, e); q0.push_back(e);
    model_step(1, rn, tk, st, l, r, ld, e); q1.push_back(e);
    @(negedge clk);
    frame_tick = 0; start = 0; rst_n = 1;
  endtask

  task automatic check_inst(input int i, input exp_t e, input logic [9:0] px, input logic [9:0] py,
                            input logic [7:0] vy, input logic [1:0] st, input logic b,
                            input logic sv, input logic [5:0] sa, input logic d);
    cmp("pos_x", i, int'(px), e.x);
    cmp("pos_y", i, int'(py), e.y);
    cmp("vel_y", i, int'($signed(vy)), e.v);
    cmp("state", i, int'(st), e.s);
    cmp("bounce", i, int'(b), int'(e.b));
    cmp("scroll_vld", i, int'(sv), int'(e.sv));
    cmp("dead", i, int'(d), int'(e.d));
    if (e.chk_amt) cmp("scroll_amt", i, int'(sa), e.amt);
  endtask

  bit   ev_s;
  exp_t e_m;

  always begin
    @(posedge clk);
    ev_s = frame_tick || start || !rst_n;
    #1;
    if (ev_s) begin
      if (q0.size() == 0) cmp("q0_underflow", 0, 1, 0);
      else begin
        e_m = q0.pop_front();
        check_inst(0, e_m, px0, py0, vy0, st0, b0, sv0, sa0, d0);
      end
      if (q1.size() == 0) cmp("q1_underflow", 1, 1, 0);
      else begin
        e_m = q1.pop_front();
        check_inst(1, e_m, px1, py1, vy1, st1, b1, sv1, sa1, d1);
      end
    end else begin
      cmp("bounce_quiet", 0, int'(b0), 0);
      cmp("scroll_vld_quiet", 0, int'(sv0), 0);
      cmp("bounce_quiet", 1, int'(b1), 0);
      cmp("scroll_vld_quiet", 1, int'(sv1), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x76;
    frame_tick = 0; start = 0; btn_left = 0; btn_right = 0; land = 0; rst_n = 0;
    hand(0, N, N, N, N, N); hand(1, N, N, N, N, N);
    model_reset(0); model_reset(1);

    // reset values and ignored idle ticks
    hand(0, 300, 400, 0, 0, 0); hand(1, 300, 400, 0, 0, 0);
    ev(0, 0, 0, 0, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      if (t == 10) begin hand(0, 300, 400, 0, 0, N); hand(1, 300, 400, 0, 0, N); end
      ev(1, 0, 0, 0, 0, 1);
    end

    // launch, rise to apex, fall to death; inst1 scrolls on the way up
    hand(0, 300, 400, -12, 1, N);
    ev(0, 1, 0, 0, 0, 1);
    for (int t = 1; t <= 32; t++) begin
      if (t == 1)  begin hand(0, N, 388, -11, 1, 0); hand(1, N, 395, -11, 1, 7); end
      if (t == 2)  hand(1, N, 395, -10, 1, 11);
      if (t == 12) hand(0, N, 322, 0, 1, N);
      if (t == 13) hand(0, N, 322, 1, 2, N);
      if (t == 25) hand(0, N, 400, 12, 2, N);
      if (t == 29) hand(0, N, 440, 0, 3, N);
      if (t == 32) hand(0, 300, 440, 0, 3, N);
      ev(1, 0, 0, 0, 0, 1);
    end
    hand(0, 300, 400, 0, 0, 0); hand(1, 300, 400, 0, 0, 0);
    ev(0, 1, 0, 0, 0, 1);

    // bounce in FALL, land ignored in RISE
    ev(0, 1, 0, 0, 0, 1);
    for (int t = 1; t <= 13; t++) ev(1, 0, 0, 0, 0, 1);
    hand(0, N, 323, -12, 1, N);
    ev(1, 0, 0, 0, 1, 1);
    hand(0, N, 311, -11, 1, N);
    ev(1, 0, 0, 0, 1, 1);

    // reset together with pending tick and start
    hand(0, 300, 400, 0, 0, 0); hand(1, 300, 400, 0, 0, 0);
    ev(1, 1, 0, 0, 0, 0);

    // steer left into the edge with bouncing kept alive by land
`ifdef PLAYER_WRAP_EN
    x76 = 636;
`else
    x76 = 0;
`endif
    ev(0, 1, 0, 0, 0, 1);
    for (int t = 1; t <= 76; t++) begin
      if (t == 75) begin hand(0, 0, N, N, N, N); hand(1, 0, N, N, N, N); end
      if (t == 76) begin hand(0, x76, N, N, N, N); hand(1, x76, N, N, N, N); end
      ev(1, 0, 1, 0, 1, 1);
    end
    for (int t = 1; t <= 3; t++) begin
      hand(0, x76, N, N, N, N); hand(1, x76, N, N, N, N);
      ev(1, 0, 1, 1, 1, 1);
    end
    for (int t = 1; t <= 2; t++) ev(1, 0, 0, 1, 1, 1);

    repeat (3) @(negedge clk);
    if (q0.size() != 0) cmp("q0_leftover", 0, q0.size(), 0);
    if (q1.size() != 0) cmp("q1_leftover", 1, q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
